// File: rtl/instr_feeder_pkg.sv
`default_nettype none
// ============================================================================
// Module  : instr_feeder_pkg
// Brief   : Shared constants, FSM state codes and default program table for
//           instr_feeder / feeder_mem.
// Rev     : 1.0  initial release
// ============================================================================
package instr_feeder_pkg;

    localparam logic [15:0] HALT_WORD = 16'hFFFF;
    localparam logic [2:0]  OPC_MVI   = 3'b001;
    localparam int          OPC_MSB   = 8;
    localparam int          OPC_LSB   = 6;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ISSUE = 3'd1;
    localparam logic [2:0] ST_IMM   = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_HALT  = 3'd4;

    // Word 1 is an immediate on the first pass, but becomes the halt
    // instruction once the mvi at word 31 swallows word 0 after the wrap.
    function automatic logic [15:0] default_prog(input logic [31:0] addr);
        logic [15:0] w;
        case (addr)
            32'd0:   w = 16'h0040;
            32'd1:   w = 16'hFFFF;
            32'd2:   w = 16'h0080;
            32'd3:   w = 16'h0040;
            32'd4:   w = 16'h1234;
            32'd31:  w = 16'h0040;
            default: w = 16'h0000;
        endcase
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_feeder_mem.sv
`default_nettype none
// ============================================================================
// Module  : feeder_mem
// Brief   : DEPTH x 16 program memory, combinational read. With FEEDER_LOAD_EN
//           defined it is a writable RAM, otherwise a constant ROM.
// Rev     : 1.0  initial release
// ============================================================================
module feeder_mem
    import instr_feeder_pkg::*;
#(
    parameter int DEPTH = 32
) (
`ifdef FEEDER_LOAD_EN
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [15:0]              wdata_i,
`endif
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [15:0]              rdata_o
);

`ifdef FEEDER_LOAD_EN
    // No reset on the array: reset must never disturb a loaded program.
    logic [15:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata_o = mem_q[raddr_i];
    end
`else
    always_comb begin
        rdata_o = default_prog(32'(raddr_i));
    end
`endif

endmodule
`default_nettype wire

// File: rtl/instr_feeder.sv
`default_nettype none
// ============================================================================
// Module  : instr_feeder
// Brief   : Issues program words to a processor with a Run/Done handshake;
//           mvi instructions are followed by their immediate word.
//           Optional load port enabled by macro FEEDER_LOAD_EN.
// Rev     : 1.0  initial release
// ============================================================================
module instr_feeder
    import instr_feeder_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic                     Clock,
    input  logic                     Resetn,
    input  logic                     Start,
    input  logic                     Done,
`ifdef FEEDER_LOAD_EN
    input  logic                     LdEn,
    input  logic [$clog2(DEPTH)-1:0] LdAddr,
    input  logic [15:0]              LdData,
`endif
    output logic [15:0]              DIN,
    output logic                     Run,
    output logic [$clog2(DEPTH)-1:0] PC,
    output logic                     Halted
);

    localparam int AW = $clog2(DEPTH);

    logic [2:0]    state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [15:0]   din_q, din_d;
    logic [15:0]   mem_word;
    logic [2:0]    opc;

    function automatic logic [AW-1:0] pc_inc(input logic [AW-1:0] pc);
        return (pc == AW'(DEPTH - 1)) ? '0 : pc + AW'(1);
    endfunction

`ifdef FEEDER_LOAD_EN
    logic mem_we;
    assign mem_we = LdEn && ((state_q == ST_IDLE) || (state_q == ST_HALT));

    feeder_mem #(.DEPTH(DEPTH)) u_mem (
        .clk_i   (Clock),
        .we_i    (mem_we),
        .waddr_i (LdAddr),
        .wdata_i (LdData),
        .raddr_i (pc_q),
        .rdata_o (mem_word)
    );
`else
    feeder_mem #(.DEPTH(DEPTH)) u_mem (
        .raddr_i (pc_q),
        .rdata_o (mem_word)
    );
`endif

    assign opc = mem_word[OPC_MSB:OPC_LSB];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        din_d   = din_q;
        Run     = 1'b0;
        DIN     = 16'h0000;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (mem_word == HALT_WORD) begin
                    state_d = ST_HALT;
                end else begin
                    Run     = 1'b1;
                    DIN     = mem_word;
                    din_d   = mem_word;
                    pc_d    = pc_inc(pc_q);
                    state_d = (opc == OPC_MVI) ? ST_IMM : ST_WAIT;
                end
            end
            ST_IMM: begin
                DIN     = mem_word;
                din_d   = mem_word;
                pc_d    = pc_inc(pc_q);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                DIN = din_q;
                if (Done) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_HALT: begin
                if (Start) begin
                    pc_d    = '0;
                    state_d = ST_ISSUE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            din_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            din_q   <= din_d;
        end
    end

    assign PC     = pc_q;
    assign Halted = (state_q == ST_HALT);

endmodule
`default_nettype wire

// File: tb/tb_instr_feeder.sv
`default_nettype none
// ============================================================================
// Module  : tb_instr_feeder
// Brief   : Self-checking bench for instr_feeder with a behavioural model of
//           the issue sequence (default program table, optional load port).
// Rev     : 1.0  initial release
// ============================================================================
module tb_instr_feeder;

    logic        Clock = 1'b0;
    logic        Resetn = 1'b0;
    logic        Start = 1'b0;
    logic        Done = 1'b0;
    logic [15:0] DIN;
    logic        Run;
    logic [4:0]  PC;
    logic        Halted;
`ifdef FEEDER_LOAD_EN
    logic        LdEn = 1'b0;
    logic [4:0]  LdAddr = 5'd0;
    logic [15:0] LdData = 16'h0000;
`endif

    int tests = 0;
    int fails = 0;

    instr_feeder #(.DEPTH(32)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .Start  (Start),
        .Done   (Done),
`ifdef FEEDER_LOAD_EN
        .LdEn   (LdEn),
        .LdAddr (LdAddr),
        .LdData (LdData),
`endif
        .DIN    (DIN),
        .Run    (Run),
        .PC     (PC),
        .Halted (Halted)
    );

    always #5 Clock = ~Clock;

    // ---------------- behavioural model ----------------
    typedef enum {M_IDLE, M_FETCH, M_OPERAND, M_BLOCKED, M_STOPPED} mphase_t;
    mphase_t     mph = M_IDLE;
    int          mpc = 0;
    logic [15:0] mlast = 16'h0000;
    logic [15:0] prog [32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) prog[i] = 16'h0000;
        prog[0]  = 16'h0040;
        prog[1]  = 16'hFFFF;
        prog[2]  = 16'h0080;
        prog[3]  = 16'h0040;
        prog[4]  = 16'h1234;
        prog[31] = 16'h0040;
    end

    initial begin
        forever begin
            @(posedge Clock or negedge Resetn);
            if (!Resetn) begin
                mph = M_IDLE; mpc = 0; mlast = 16'h0000;
            end else begin
`ifdef FEEDER_LOAD_EN
                if (LdEn && (mph == M_IDLE || mph == M_STOPPED)) prog[LdAddr] = LdData;
`endif
                case (mph)
                    M_IDLE:    if (Start) mph = M_FETCH;
                    M_FETCH: begin
                        if (prog[mpc] == 16'hFFFF) mph = M_STOPPED;
                        else begin
                            mlast = prog[mpc];
                            mph   = (prog[mpc][8:6] == 3'b001) ? M_OPERAND : M_BLOCKED;
                            mpc   = (mpc + 1) % 32;
                        end
                    end
                    M_OPERAND: begin
                        mlast = prog[mpc];
                        mpc   = (mpc + 1) % 32;
                        mph   = M_BLOCKED;
                    end
                    M_BLOCKED: if (Done) mph = M_FETCH;
                    M_STOPPED: if (Start) begin mpc = 0; mph = M_FETCH; end
                    default:   mph = M_IDLE;
                endcase
            end
        end
    end

    // Compare process: every falling edge, DUT vs model.
    logic prev_run = 1'b0;
    initial begin
        forever begin
            @(negedge Clock);
            begin
                logic        e_run;
                logic [15:0] e_din;
                logic        din_defined;
                e_run = (mph == M_FETCH) && (prog[mpc] != 16'hFFFF);
                din_defined = 1'b1;
                case (mph)
                    M_FETCH:   begin e_din = prog[mpc]; din_defined = e_run; end
                    M_OPERAND: e_din = prog[mpc];
                    M_BLOCKED: e_din = mlast;
                    default:   e_din = 16'h0000;
                endcase
                chk("model_run", {31'd0, Run}, {31'd0, e_run});
                chk("model_pc", {27'd0, PC}, 32'(mpc));
                chk("model_halted", {31'd0, Halted}, {31'd0, (mph == M_STOPPED)});
                if (din_defined) chk("model_din", {16'd0, DIN}, {16'd0, e_din});
                chk("run_not_back_to_back", {31'd0, prev_run & Run}, 32'd0);
                prev_run = Run;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic s, input logic d);
        Start = s;
        Done  = d;
        @(negedge Clock);
    endtask

    task automatic expect_out(input string name, input logic r, input logic [15:0] d,
                              input logic [4:0] p, input logic h);
        chk({name, "_run"}, {31'd0, Run}, {31'd0, r});
        chk({name, "_din"}, {16'd0, DIN}, {16'd0, d});
        chk({name, "_pc"}, {27'd0, PC}, {27'd0, p});
        chk({name, "_halted"}, {31'd0, Halted}, {31'd0, h});
    endtask

    int run_count;
    int guard;

    initial begin
        Resetn = 1'b0;
        repeat (3) @(negedge Clock);
        expect_out("reset", 1'b0, 16'h0000, 5'd0, 1'b0);
        #1 Resetn = 1'b1;
`ifdef FEEDER_LOAD_EN
        for (int i = 0; i < 32; i++) begin
            LdEn = 1'b1; LdAddr = 5'(i); LdData = prog[i];
            step(1'b0, 1'b0);
        end
        LdEn = 1'b0;
`endif
        // Done in IDLE must be ignored
        step(1'b0, 1'b1);
        expect_out("idle_done_ignored", 1'b0, 16'h0000, 5'd0, 1'b0);

        step(1'b1, 1'b0);
        expect_out("first_issue", 1'b1, 16'h0040, 5'd0, 1'b0);
        step(1'b0, 1'b0);
        expect_out("first_imm", 1'b0, 16'hFFFF, 5'd1, 1'b0);
        step(1'b0, 1'b0);
        expect_out("first_wait", 1'b0, 16'hFFFF, 5'd2, 1'b0);

        // Long WAIT with Start asserted: nothing may move
`ifdef FEEDER_LOAD_EN
        LdEn = 1'b1; LdAddr = 5'd3; LdData = 16'hBEEF;
`endif
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0);
            expect_out("wait_hold", 1'b0, 16'hFFFF, 5'd2, 1'b0);
        end
`ifdef FEEDER_LOAD_EN
        LdEn = 1'b0;
`endif
        step(1'b0, 1'b1);
        expect_out("done_to_issue", 1'b1, 16'h0080, 5'd2, 1'b0);
        step(1'b0, 1'b0);
        expect_out("mv_wait", 1'b0, 16'h0080, 5'd3, 1'b0);
        step(1'b0, 1'b1);
        expect_out("mvi_issue", 1'b1, 16'h0040, 5'd3, 1'b0);
        step(1'b0, 1'b0);
        expect_out("mvi_imm", 1'b0, 16'h1234, 5'd4, 1'b0);
        step(1'b0, 1'b0);
        expect_out("mvi_wait", 1'b0, 16'h1234, 5'd5, 1'b0);

        // Asynchronous reset in WAIT, checked before the next rising edge
        #2 Resetn = 1'b0;
        #1 expect_out("async_reset", 1'b0, 16'h0000, 5'd0, 1'b0);
        @(negedge Clock);
        #1 Resetn = 1'b1;
        step(1'b0, 1'b0);
        expect_out("after_reset_idle", 1'b0, 16'h0000, 5'd0, 1'b0);

        // Full pass with Done held high: wraps at 31, mvi immediate from word 0, halts at word 1
        step(1'b1, 1'b0);
        run_count = Run ? 1 : 0;
        guard = 0;
        while (!Halted && guard < 200) begin
            step(1'b0, 1'b1);
            if (Run) run_count++;
            guard++;
        end
        chk("halt_reached_in_budget", {31'd0, Halted}, 32'd1);
        chk("run_pulses_full_pass", 32'(run_count), 32'd30);
        expect_out("halt_state", 1'b0, 16'h0000, 5'd1, 1'b1);
        step(1'b0, 1'b1);
        expect_out("halt_stays", 1'b0, 16'h0000, 5'd1, 1'b1);

        step(1'b1, 1'b0);
        expect_out("restart_from_halt", 1'b1, 16'h0040, 5'd0, 1'b0);
        step(1'b0, 1'b0);
        expect_out("restart_imm", 1'b0, 16'hFFFF, 5'd1, 1'b0);

`ifdef FEEDER_LOAD_EN
        Resetn = 1'b0;
        @(negedge Clock);
        #1 Resetn = 1'b1;
        LdEn = 1'b1; LdAddr = 5'd3; LdData = 16'hABCD;
        step(1'b0, 1'b0);
        LdEn = 1'b0;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        expect_out("loaded_word3", 1'b1, 16'hABCD, 5'd3, 1'b0);
        step(1'b0, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
